// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - ALU_WIDTH : default operand/result width
//   - ALU_*     : 4-bit ALUControl operation codes
//   - alu_op_is_sub() : true for ops that drive the shared adder in subtract mode
// Optional feature: define ALU_OVERFLOW_EN to add the registered overflow port to alu.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  // SUB and both set-less-than ops all need a - b from the shared adder.
  function automatic logic alu_op_is_sub(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: WIDTH-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
// Ports:
//   a, b   in  WIDTH  operands
//   sub    in  1      0: a + b, 1: a - b (computed as a + ~b + 1)
//   sum    out WIDTH  result modulo 2^WIDTH
//   carry  out 1      carry out of the MSB (for subtract, 1 means no borrow)
//   ovf    out 1      two's-complement signed overflow
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;

  always_comb begin
    b_eff    = sub ? ~b : b;
    full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum      = full_sum[WIDTH-1:0];
    carry    = full_sum[WIDTH];
    // Same-sign effective operands producing a result of the other sign.
    ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU for the MIPS execute stage.
// Ports:
//   clk         in  1      rising-edge clock
//   reset       in  1      asynchronous active-high reset
//   a, b        in  WIDTH  operands (b[$clog2(WIDTH)-1:0] is the shift amount)
//   ALUControl  in  4      operation select (codes in alu_pkg)
//   result      out WIDTH  registered operation result
//   zeroes      out 1      registered flag, 1 when result is zero
//   overflow    out 1      registered signed overflow for ADD/SUB
//                          (present only when ALU_OVERFLOW_EN is defined)
// Latency is one cycle; a new operation may be issued every cycle.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result,
  output logic             zeroes
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zeroes_d, zeroes_q;

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (alu_op_is_sub(ALUControl)),
    .sum  (sum),
    .carry(carry),
    .ovf  (ovf)
  );

  assign shamt = b[ShW-1:0];

  always_comb begin
    result_d = '0;
    case (ALUControl)
      ALU_AND:  result_d = a & b;
      ALU_OR:   result_d = a | b;
      ALU_ADD:  result_d = sum;
      ALU_XOR:  result_d = a ^ b;
      ALU_NOR:  result_d = ~(a | b);
      ALU_SUB:  result_d = sum;
      // Sign of a - b, corrected when the subtraction overflowed.
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      // A borrow (no carry out of a + ~b + 1) means a < b unsigned.
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, ~carry};
      ALU_SLL:  result_d = a << shamt;
      ALU_SRL:  result_d = a >> shamt;
      ALU_SRA:  result_d = WIDTH'($signed(a) >>> shamt);
      default:  result_d = '0;
    endcase
    // Flag derived from the next result so it updates on the same edge.
    zeroes_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zeroes_q <= 1'b1;
    end else begin
      result_q <= result_d;
      zeroes_q <= zeroes_d;
    end
  end

  assign result = result_q;
  assign zeroes = zeroes_q;

`ifdef ALU_OVERFLOW_EN
  logic overflow_d, overflow_q;

  // The adder's overflow already matches both ADD and SUB rules; other ops report 0.
  assign overflow_d = ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB)) && ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ALUControl;
  logic [31:0] result;
  logic        zeroes;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_tests;
  int n_fail;

  alu #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .ALUControl(ALUControl),
`ifdef ALU_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .result    (result),
    .zeroes    (zeroes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  // Reference model in plain arithmetic terms.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy;
    int     sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % 32);
    case (op)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000);
      4'd3:    return x ^ y;
      4'd4:    return ~(x | y);
      4'd6:    return 32'((longint'(x) - longint'(y) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'd7:    return (sx < sy) ? 32'd1 : 32'd0;
      4'd8:    return (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
      4'd9:    return 32'((longint'(x) * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd10:   return 32'(longint'(x) / (64'd1 << sh));
      4'd11:   return 32'(sx >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
    longint r;
    if (op == 4'd2)      r = longint'($signed(x)) + longint'($signed(y));
    else if (op == 4'd6) r = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    ALUControl = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
    apply(op, x, y);
    check32({name, ".result"}, result, exp);
    check1({name, ".zeroes"}, zeroes, exp == 32'd0);
`ifdef ALU_OVERFLOW_EN
    check1({name, ".overflow"}, overflow, model_ovf(op, x, y));
`endif
  endtask

  logic [31:0] specials[5];

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'hFFFF_FFFF;

    vecs[0]  = '{ALU_AND,  32'h0000_000C, 32'h0000_000A, 32'h0000_0008};
    vecs[1]  = '{ALU_AND,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{ALU_OR,   32'h0000_000C, 32'h0000_000A, 32'h0000_000E};
    vecs[3]  = '{ALU_OR,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{ALU_ADD,  32'h0000_000C, 32'h0000_000A, 32'h0000_0016};
    vecs[5]  = '{ALU_SUB,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{ALU_SUB,  32'h0000_000A, 32'h0000_000C, 32'hFFFF_FFFE};
    vecs[7]  = '{ALU_XOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{ALU_XOR,  32'h0000_000C, 32'h0000_000A, 32'h0000_0006};
    vecs[9]  = '{ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[10] = '{ALU_SLT,  32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    vecs[11] = '{ALU_SLTU, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001};
    vecs[12] = '{ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[13] = '{ALU_NOR,  32'h0000_000C, 32'h0000_000A, 32'hFFFF_FFF1};
    vecs[14] = '{ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[15] = '{ALU_SLL,  32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678};
    vecs[16] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[17] = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[18] = '{ALU_SRA,  32'h8765_4321, 32'h0000_0000, 32'h8765_4321};
    vecs[19] = '{4'b0101,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[20] = '{4'b1111,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[21] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};

    // Reset state without any clock edge.
    reset      = 1'b1;
    a          = 32'h0;
    b          = 32'h0;
    ALUControl = 4'h0;
    #2;
    check32("reset.result", result, 32'h0);
    check1("reset.zeroes", zeroes, 1'b1);
`ifdef ALU_OVERFLOW_EN
    check1("reset.overflow", overflow, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

`ifdef ALU_OVERFLOW_EN
    apply(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check32("ovf_add.result", result, 32'h8000_0000);
    check1("ovf_add.overflow", overflow, 1'b1);
    apply(ALU_ADD, 32'h0000_0001, 32'h0000_0001);
    check1("no_ovf_add.overflow", overflow, 1'b0);
    apply(ALU_SUB, 32'h8000_0000, 32'h0000_0001);
    check1("ovf_sub.overflow", overflow, 1'b1);
`endif

    // Reset asserted between edges clears outputs immediately.
    apply(ALU_OR, 32'h0000_000C, 32'h0000_000A);
    check32("pre_reset.result", result, 32'h0000_000E);
    #2;
    reset = 1'b1;
    #1;
    check32("midreset.result", result, 32'h0);
    check1("midreset.zeroes", zeroes, 1'b1);
`ifdef ALU_OVERFLOW_EN
    check1("midreset.overflow", overflow, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Randomised ops, back-to-back every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x  = pick();
      y  = ($urandom_range(0, 2) == 0) ? x : pick();
      check_op($sformatf("rand%0d_op%0d", i, op), op, x, y, model(op, x, y));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
